lane_tick_timer: RTL

//   Multi-lane successor to the single-channel rate divider/display counter pair.
//   NUM_LANES independent timers, each with a runtime-programmable period.

---
 rtl/crossy_timing_pkg.sv | 36 +++
 rtl/lane_tick_channel.sv | 87 ++++++++
 rtl/lane_tick_timer.sv | 66 ++++++
 3 files changed

// File: rtl/crossy_timing_pkg.sv
// Shared timing constants and types for the lane tick timer.
// Speed presets are expressed in clock cycles per lane step.
package crossy_timing_pkg;

  localparam int unsigned DEFAULT_CLOCK_FREQUENCY = 50_000_000;

  localparam int unsigned SPEED_FAST = DEFAULT_CLOCK_FREQUENCY;
  localparam int unsigned SPEED_MED  = 2 * DEFAULT_CLOCK_FREQUENCY;
  localparam int unsigned SPEED_SLOW = 4 * DEFAULT_CLOCK_FREQUENCY;

  // Wide enough that any CfgLane value fits without truncation before the range check.
  localparam int LANE_IDX_W = 16;
  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } lane_dir_e;

  typedef enum logic [1:0] {
    SPEED_SEL_FAST = 2'd0,
    SPEED_SEL_MED  = 2'd1,
    SPEED_SEL_SLOW = 2'd2
  } speed_sel_e;

  // Preset period for a build whose clock differs from the default.
  function automatic int unsigned speed_preset(input int unsigned clock_frequency,
                                               input speed_sel_e sel);
    case (sel)
      SPEED_SEL_MED:  return 2 * clock_frequency;
      SPEED_SEL_SLOW: return 4 * clock_frequency;
      default:        return clock_frequency;
    endcase
  endfunction

endpackage

// File: rtl/lane_tick_channel.sv
// One timer lane: period register, down counter, wrapping position and registered tick/wrap.
// Priority per edge: reset > config write > pause > count.
module lane_tick_channel
  import crossy_timing_pkg::*;
#(
  parameter int unsigned RESET_PERIOD = DEFAULT_CLOCK_FREQUENCY,
  parameter int          DIV_W        = 28,
  parameter int          POS_W        = 4,
  parameter int          POS_MAX      = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_period,
  input  logic             dir,
  output logic             tick,
  output logic             wrap,
  output logic [POS_W-1:0] position
);

  localparam logic [DIV_W-1:0] RESET_P     = DIV_W'(RESET_PERIOD);
  localparam logic [DIV_W-1:0] RESET_COUNT = DIV_W'(RESET_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
  localparam logic [POS_W-1:0] POS_LAST    = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);

  logic [DIV_W-1:0] period, period_next;
  logic [DIV_W-1:0] count, count_next;
  logic [POS_W-1:0] position_next;
  logic             tick_next, wrap_next;
  logic [POS_W-1:0] step_pos;
  logic             step_wrap;

  always_comb begin
    step_pos  = position;
    step_wrap = 1'b0;
    if (lane_dir_e'(dir) == DIR_DOWN) begin
      step_wrap = (position == '0);
      step_pos  = step_wrap ? POS_LAST : position - POS_ONE;
    end else begin
      step_wrap = (position == POS_LAST);
      step_pos  = step_wrap ? '0 : position + POS_ONE;
    end
  end

  always_comb begin
    period_next   = period;
    count_next    = count;
    position_next = position;
    tick_next     = 1'b0;
    wrap_next     = 1'b0;
    if (cfg_we) begin
      period_next = cfg_period;
      count_next  = (cfg_period == '0) ? '0 : cfg_period - DIV_ONE;
    end else if (!pause) begin
      if (period == '0) begin
        // stopped lane: counter parked at zero, never underflows
        count_next = '0;
      end else if (count != '0) begin
        count_next = count - DIV_ONE;
      end else begin
        count_next    = period - DIV_ONE;
        tick_next     = 1'b1;
        wrap_next     = step_wrap;
        position_next = step_pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period   <= RESET_P;
      count    <= RESET_COUNT;
      position <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      period   <= period_next;
      count    <= count_next;
      position <= position_next;
      tick     <= tick_next;
      wrap     <= wrap_next;
    end
  end

endmodule

// File: rtl/lane_tick_timer.sv
// NUM_LANES independent programmable tick timers with wrapping position counters.
// Define LANE_DIR_EN to add the per-lane LaneDir input (1 = position counts down).
module lane_tick_timer
  import crossy_timing_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int          NUM_LANES       = 4,
  parameter int          DIV_W           = 28,
  parameter int          POS_W           = 4,
  parameter int          POS_MAX         = 15,
  localparam int         LANE_W          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       ClockIn,
  input  logic                       Reset,
  input  logic                       Pause,
  input  logic                       CfgWe,
  input  logic [LANE_W-1:0]          CfgLane,
  input  logic [DIV_W-1:0]           CfgPeriod,
`ifdef LANE_DIR_EN
  input  logic [NUM_LANES-1:0]       LaneDir,
`endif
  output logic [NUM_LANES-1:0]       Tick,
  output logic [NUM_LANES-1:0]       Wrap,
  output logic [NUM_LANES*POS_W-1:0] Position
);

  logic [NUM_LANES-1:0] write_sel;
  logic [NUM_LANES-1:0] lane_dir;
  lane_idx_t            cfg_lane_ext;

  assign cfg_lane_ext = lane_idx_t'(CfgLane);

`ifdef LANE_DIR_EN
  assign lane_dir = LaneDir;
`else
  assign lane_dir = '0;
`endif

  // An index with no matching lane selects nothing, so out-of-range writes drop out here.
  always_comb begin
    write_sel = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      write_sel[i] = CfgWe && (cfg_lane_ext == lane_idx_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_tick_channel #(
      .RESET_PERIOD (CLOCK_FREQUENCY),
      .DIV_W        (DIV_W),
      .POS_W        (POS_W),
      .POS_MAX      (POS_MAX)
    ) u_channel (
      .clk        (ClockIn),
      .reset      (Reset),
      .pause      (Pause),
      .cfg_we     (write_sel[g]),
      .cfg_period (CfgPeriod),
      .dir        (lane_dir[g]),
      .tick       (Tick[g]),
      .wrap       (Wrap[g]),
      .position   (Position[g*POS_W +: POS_W])
    );
  end

endmodule
